i2c_capture_ctrl: RTL and testbench

//  Sequences one i2c_decoder for the logic analyzer: arm, trigger on a masked byte, capture a burst of

---
 rtl/i2c_capture_ctrl_pkg.sv | 20 ++
 rtl/i2c_capture_ctrl_capture_buffer.sv | 31 +++
 rtl/i2c_capture_ctrl.sv | 107 ++++++++++
 tb/tb_i2c_capture_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_capture_ctrl_pkg.sv
// rtl/i2c_capture_ctrl_pkg.sv - shared state encodings and trigger compare for the capture controller
package i2c_capture_ctrl_pkg;

  localparam int LA_BYTE_W = 8;

  typedef enum logic [1:0] {
    LA_IDLE    = 2'd0,
    LA_ARMED   = 2'd1,
    LA_CAPTURE = 2'd2,
    LA_DONE    = 2'd3
  } la_state_t;

  // A cleared mask bit means "don't care", so an all-zero mask matches any byte.
  function automatic logic trigger_hit(input logic [LA_BYTE_W-1:0] data,
                                       input logic [LA_BYTE_W-1:0] value,
                                       input logic [LA_BYTE_W-1:0] mask);
    return ((data ^ value) & mask) == '0;
  endfunction

endpackage

// File: rtl/i2c_capture_ctrl_capture_buffer.sv
// rtl/i2c_capture_ctrl_capture_buffer.sv - DEPTH x byte register array, one write port, async read port
module capture_buffer
  import i2c_capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [LA_BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [LA_BYTE_W-1:0] rd_data
);

  logic [LA_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2c_capture_ctrl.sv
// rtl/i2c_capture_ctrl.sv - arm/trigger/capture/drain sequencer for one i2c_decoder
module i2c_capture_ctrl
  import i2c_capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [7:0]           trig_value,
  input  logic [7:0]           trig_mask,
  input  logic [AW:0]          cap_len,
  input  logic [7:0]           dec_data,
  input  logic                 dec_detected,
  output logic                 dec_detect_only,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic                 rd_empty,
  output logic [1:0]           state_o,
  output logic                 done,
  output logic [7:0]           event_cnt
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  la_state_t   state;
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_ptr;
  logic [AW:0] len_q;
  logic        hit;
  logic        can_arm;
  logic        wr_en;

  assign hit     = trigger_hit(dec_data, trig_value, trig_mask);
  assign can_arm = (state == LA_IDLE) || (state == LA_DONE);
  // Arm only acts in IDLE/DONE, where nothing is written, so only abort can block a write.
  assign wr_en   = !abort && dec_detected &&
                   (((state == LA_ARMED) && hit) || (state == LA_CAPTURE));

  assign rd_empty = (rd_ptr == wr_cnt);
  assign state_o  = state;
  assign done     = (state == LA_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= LA_IDLE;
      dec_detect_only <= 1'b1;
      wr_cnt          <= '0;
      rd_ptr          <= '0;
      len_q           <= DEPTH_L;
      event_cnt       <= 8'h00;
    end else begin
      // Follows the state one clock behind so the decoder freezes after entry to DONE.
      dec_detect_only <= can_arm;
      if (abort) begin
        state  <= LA_IDLE;
        wr_cnt <= '0;
        rd_ptr <= '0;
      end else if (arm && can_arm) begin
        state     <= LA_ARMED;
        wr_cnt    <= '0;
        rd_ptr    <= '0;
        event_cnt <= 8'h00;
        len_q     <= ((cap_len == '0) || (cap_len > DEPTH_L)) ? DEPTH_L : cap_len;
      end else begin
        if (dec_detected && (state != LA_IDLE) && (event_cnt != 8'hFF)) begin
          event_cnt <= event_cnt + 8'd1;
        end
        case (state)
          LA_ARMED: begin
            if (dec_detected && hit) begin
              wr_cnt <= (AW+1)'(1);
              state  <= (len_q == (AW+1)'(1)) ? LA_DONE : LA_CAPTURE;
            end
          end
          LA_CAPTURE: begin
            if (dec_detected) begin
              wr_cnt <= wr_cnt + 1'b1;
              if ((wr_cnt + 1'b1) == len_q) begin
                state <= LA_DONE;
              end
            end
          end
          LA_DONE: begin
            if (rd_en && !rd_empty) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  capture_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (dec_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_i2c_capture_ctrl.sv
// tb/tb_i2c_capture_ctrl.sv - directed self-checking bench for i2c_capture_ctrl
module tb_i2c_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] trig_value = 8'h00;
  logic [7:0] trig_mask = 8'h00;
  logic [3:0] cap_len = 4'd0;
  logic [7:0] dec_data = 8'h00;
  logic       dec_detected = 1'b0;
  logic       dec_detect_only;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic [1:0] state_o;
  logic       done;
  logic [7:0] event_cnt;

  int total = 0;
  int bad = 0;

  i2c_capture_ctrl #(.DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .abort           (abort),
    .trig_value      (trig_value),
    .trig_mask       (trig_mask),
    .cap_len         (cap_len),
    .dec_data        (dec_data),
    .dec_detected    (dec_detected),
    .dec_detect_only (dec_detect_only),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .state_o         (state_o),
    .done            (done),
    .event_cnt       (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dec_data = b;
    dec_detected = 1'b1;
    tick();
    dec_detected = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] len, input logic [7:0] val, input logic [7:0] msk);
    cap_len = len;
    trig_value = val;
    trig_mask = msk;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (dec_detect_only !== 1'b1) begin bad++; $display("FAIL reset_detect_only got=%b exp=1", dec_detect_only); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL reset_rd_empty got=%b exp=1", rd_empty); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (event_cnt !== 8'h00) begin bad++; $display("FAIL reset_event_cnt got=%h exp=00", event_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_trigger_capture();
    do_arm(4'd3, 8'hA0, 8'hFF);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL t1_armed got=%0d exp=1", state_o); end
    send_byte(8'h12);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL t1_nomatch_state got=%0d exp=1", state_o); end
    total++; if (dec_detect_only !== 1'b0) begin bad++; $display("FAIL t1_detect_only_low got=%b exp=0", dec_detect_only); end
    send_byte(8'hA0);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL t1_capture got=%0d exp=2", state_o); end
    send_byte(8'h34);
    send_byte(8'h56);
    total++; if (state_o !== 2'd3 || done !== 1'b1) begin bad++; $display("FAIL t1_done got=%0d/%b exp=3/1", state_o, done); end
    total++; if (event_cnt !== 8'd4) begin bad++; $display("FAIL t1_event_at_done got=%0d exp=4", event_cnt); end
    total++; if (dec_detect_only !== 1'b0) begin bad++; $display("FAIL t1_detect_only_lag got=%b exp=0", dec_detect_only); end
    send_byte(8'h78);
    total++; if (event_cnt !== 8'd5) begin bad++; $display("FAIL t1_event_missed got=%0d exp=5", event_cnt); end
    total++; if (dec_detect_only !== 1'b1) begin bad++; $display("FAIL t1_detect_only_high got=%b exp=1", dec_detect_only); end
    total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL t1_not_empty got=%b exp=0", rd_empty); end
  endtask

  task automatic test_readout();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'hA0;
    exp_data[1] = 8'h34;
    exp_data[2] = 8'h56;
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_data !== exp_data[i]) begin bad++; $display("FAIL t3_rd_data[%0d] got=%h exp=%h", i, rd_data, exp_data[i]); end
      pulse_rd();
    end
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL t3_empty got=%b exp=1", rd_empty); end
    pulse_rd();
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL t3_no_wrap got=%b exp=1", rd_empty); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL t3_rd_data_after got=%h exp=00", rd_data); end
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL t3_state got=%0d exp=3", state_o); end
  endtask

  task automatic test_arm_vs_byte();
    cap_len = 4'd2;
    trig_value = 8'h55;
    trig_mask = 8'hFF;
    arm = 1'b1;
    dec_data = 8'h55;
    dec_detected = 1'b1;
    tick();
    arm = 1'b0;
    dec_detected = 1'b0;
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL t5_state got=%0d exp=1", state_o); end
    total++; if (event_cnt !== 8'd0) begin bad++; $display("FAIL t5_event got=%0d exp=0", event_cnt); end
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL t5_not_stored got=%b exp=1", rd_empty); end
  endtask

  task automatic test_abort();
    do_abort();
    do_arm(4'd5, 8'h55, 8'hFF);
    send_byte(8'h55);
    send_byte(8'h66);
    total++; if (state_o !== 2'd2 || rd_empty !== 1'b0) begin bad++; $display("FAIL t4_capture got=%0d/%b exp=2/0", state_o, rd_empty); end
    do_arm(4'd1, 8'h00, 8'h00);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL t4_arm_ignored got=%0d exp=2", state_o); end
    do_abort();
    total++; if (state_o !== 2'd0 || rd_empty !== 1'b1) begin bad++; $display("FAIL t4_abort got=%0d/%b exp=0/1", state_o, rd_empty); end
    total++; if (event_cnt !== 8'd2) begin bad++; $display("FAIL t4_event_hold got=%0d exp=2", event_cnt); end
    send_byte(8'h99);
    total++; if (dec_detect_only !== 1'b1) begin bad++; $display("FAIL t4_detect_only got=%b exp=1", dec_detect_only); end
    total++; if (event_cnt !== 8'd2) begin bad++; $display("FAIL t4_idle_not_counted got=%0d exp=2", event_cnt); end
  endtask

  task automatic test_full_depth();
    do_arm(4'd0, 8'hC3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i));
      if (i == 0 || i == 6) begin
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL t2_capture[%0d] got=%0d exp=2", i, state_o); end
      end
    end
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL t2_done got=%0d exp=3", state_o); end
    send_byte(8'hEE);
    total++; if (event_cnt !== 8'd9) begin bad++; $display("FAIL t2_event got=%0d exp=9", event_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rd_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL t2_rd_data[%0d] got=%h exp=%h", i, rd_data, 8'h10 + 8'(i)); end
      pulse_rd();
    end
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL t2_ninth_not_stored got=%b exp=1", rd_empty); end
  endtask

  task automatic test_saturate_and_rst();
    do_arm(4'd1, 8'h5A, 8'hFF);
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h01);
    end
    total++; if (event_cnt !== 8'hFF || state_o !== 2'd1) begin bad++; $display("FAIL t6_saturate got=%h/%0d exp=ff/1", event_cnt, state_o); end
    send_byte(8'h5A);
    total++; if (state_o !== 2'd3 || rd_data !== 8'h5A) begin bad++; $display("FAIL t6_len1 got=%0d/%h exp=3/5a", state_o, rd_data); end
    total++; if (event_cnt !== 8'hFF) begin bad++; $display("FAIL t6_sat_hold got=%h exp=ff", event_cnt); end
    do_arm(4'd4, 8'h5A, 8'hFF);
    send_byte(8'h5A);
    total++; if (state_o !== 2'd2 || event_cnt !== 8'd1) begin bad++; $display("FAIL t6_recapture got=%0d/%0d exp=2/1", state_o, event_cnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (state_o !== 2'd0 || done !== 1'b0) begin bad++; $display("FAIL t6_async_state got=%0d/%b exp=0/0", state_o, done); end
    total++; if (rd_empty !== 1'b1 || rd_data !== 8'h00) begin bad++; $display("FAIL t6_async_buf got=%b/%h exp=1/00", rd_empty, rd_data); end
    total++; if (event_cnt !== 8'h00 || dec_detect_only !== 1'b1) begin bad++; $display("FAIL t6_async_misc got=%h/%b exp=00/1", event_cnt, dec_detect_only); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_trigger_capture();
    test_readout();
    test_arm_vs_byte();
    test_abort();
    test_full_depth();
    test_saturate_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
